// File: rtl/llc_snoop_responder_pkg.sv
// llc_snoop_responder_pkg: cache sizes, set/way layout, MESI states and the snoop op/result encodings
package llc_snoop_responder_pkg;
  localparam int ADDR_SIZE = 32;
  localparam int OFFSET_SIZE = 6;
  localparam int INDEX_SIZE = 14;
  localparam int TAG_SIZE = ADDR_SIZE - INDEX_SIZE - OFFSET_SIZE;
  localparam int N_WAY = 16;
  localparam int WAY_BITS = $clog2(N_WAY);
  typedef enum logic [1:0] {INVALID = 2'd0, SHARED = 2'd1, EXCLUSIVE = 2'd2, MODIFIED = 2'd3} mesi_e;
  typedef struct packed {
    logic valid;
    logic dirty;
    mesi_e mesi;
    logic [TAG_SIZE-1:0] tag;
  } way_st;
  typedef struct packed {
    way_st [N_WAY-1:0] way;
    logic [N_WAY-2:0] plru_bits;
  } set_st;
  typedef enum logic [1:0] {READ = 2'd0, WRITE = 2'd1, INVALIDATE = 2'd2, RWIM = 2'd3} snoop_op_e;
  typedef enum logic [1:0] {HIT = 2'd0, HITM = 2'd1, NOHIT = 2'd2} snoop_res_e;
  function automatic logic [TAG_SIZE-1:0] addr_tag(input logic [ADDR_SIZE-1:0] a);
    return a[ADDR_SIZE-1 -: TAG_SIZE];
  endfunction
  function automatic logic [INDEX_SIZE-1:0] addr_index(input logic [ADDR_SIZE-1:0] a);
    return a[OFFSET_SIZE +: INDEX_SIZE];
  endfunction
endpackage

// File: rtl/llc_snoop_responder_if.sv
// llc_snoop_responder_if: snoop request/result, set read/write and writeback signals; slave = responder, master = bus and set storage
interface llc_snoop_responder_if;
  import llc_snoop_responder_pkg::*;
  logic snoop_valid;
  logic snoop_ready;
  snoop_op_e snoop_op;
  logic [ADDR_SIZE-1:0] snoop_addr;
  logic set_rd_en;
  logic [INDEX_SIZE-1:0] set_rd_index;
  set_st set_rd_data;
  logic set_wr_en;
  logic [INDEX_SIZE-1:0] set_wr_index;
  set_st set_wr_data;
  logic wb_valid;
  logic wb_ready;
  logic [ADDR_SIZE-1:0] wb_addr;
  logic snoop_res_valid;
  snoop_res_e snoop_res;
  logic protocol_err;
  modport slave (
    input snoop_valid, snoop_op, snoop_addr, set_rd_data, wb_ready,
    output snoop_ready, set_rd_en, set_rd_index, set_wr_en, set_wr_index, set_wr_data,
    output wb_valid, wb_addr, snoop_res_valid, snoop_res, protocol_err
  );
  modport master (
    output snoop_valid, snoop_op, snoop_addr, set_rd_data, wb_ready,
    input snoop_ready, set_rd_en, set_rd_index, set_wr_en, set_wr_index, set_wr_data,
    input wb_valid, wb_addr, snoop_res_valid, snoop_res, protocol_err
  );
endinterface

// File: rtl/llc_snoop_responder_snoop_way_match.sv
// snoop_way_match: combinational tag compare over all valid ways (set_data, tag in; hit, lowest matching way, multi-hit out)
module snoop_way_match
  import llc_snoop_responder_pkg::*;
(
  input set_st set_data,
  input logic [TAG_SIZE-1:0] tag,
  output logic hit,
  output logic [WAY_BITS-1:0] way,
  output logic multi
);
  always_comb begin
    hit = 1'b0;
    way = '0;
    multi = 1'b0;
    for (int i = N_WAY - 1; i >= 0; i--) begin
      if (set_data.way[i].valid && set_data.way[i].tag == tag) begin
        multi = multi | hit;
        hit = 1'b1;
        way = WAY_BITS'(i);
      end
    end
  end
endmodule

// File: rtl/llc_snoop_responder.sv
// llc_snoop_responder: answers snooped bus ops with HIT/HITM/NOHIT, applies MESI downgrade, writes back M lines (clk, rst, bus slave modport)
module llc_snoop_responder
  import llc_snoop_responder_pkg::*;
(
  input logic clk,
  input logic rst,
  llc_snoop_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOOKUP, WB, DONE} state_e;
  state_e state;
  snoop_op_e op_q;
  logic [TAG_SIZE-1:0] tag_q;
  logic [INDEX_SIZE-1:0] idx_q;
  logic hit;
  logic multi;
  logic err;
  logic chg;
  logic [WAY_BITS-1:0] way;
  mesi_e cur;
  mesi_e nxt;
  snoop_res_e res;
  set_st upd;
  snoop_way_match u_match (
    .set_data(bus.set_rd_data),
    .tag(tag_q),
    .hit(hit),
    .way(way),
    .multi(multi)
  );
  assign bus.snoop_ready = state == IDLE;
  assign bus.set_rd_en = state == IDLE && bus.snoop_valid;
  assign bus.set_rd_index = bus.set_rd_en ? addr_index(bus.snoop_addr) : '0;
  always_comb begin
    cur = bus.set_rd_data.way[way].mesi;
    res = !hit ? NOHIT
        : (op_q == READ || op_q == RWIM) ? (cur == MODIFIED ? HITM : cur == INVALID ? NOHIT : HIT)
        : (op_q == INVALIDATE && cur == SHARED) ? HIT : NOHIT;
    nxt = (!hit || cur == INVALID) ? cur
        : op_q == READ ? SHARED
        : (op_q == RWIM || (op_q == INVALIDATE && cur == SHARED)) ? INVALID : cur;
    err = multi | (hit && (op_q == INVALIDATE || op_q == WRITE) && (cur == MODIFIED || cur == EXCLUSIVE));
    chg = nxt != cur;
    upd = bus.set_rd_data;
    upd.way[way].mesi = nxt;
    upd.way[way].dirty = upd.way[way].dirty & (cur != MODIFIED);
    upd.way[way].valid = upd.way[way].valid & (nxt != INVALID);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_q <= READ;
      tag_q <= '0;
      idx_q <= '0;
      bus.set_wr_en <= 1'b0;
      bus.set_wr_index <= '0;
      bus.set_wr_data <= '0;
      bus.wb_valid <= 1'b0;
      bus.wb_addr <= '0;
      bus.snoop_res_valid <= 1'b0;
      bus.snoop_res <= HIT;
      bus.protocol_err <= 1'b0;
    end else begin
      bus.set_wr_en <= 1'b0;
      bus.snoop_res_valid <= 1'b0;
      bus.protocol_err <= 1'b0;
      case (state)
        IDLE: if (bus.snoop_valid) begin
          op_q <= bus.snoop_op;
          tag_q <= addr_tag(bus.snoop_addr);
          idx_q <= addr_index(bus.snoop_addr);
          state <= LOOKUP;
        end
        LOOKUP: begin
          bus.protocol_err <= err;
          bus.snoop_res <= res;
          bus.set_wr_data <= upd;
          bus.set_wr_index <= idx_q;
          if (res == HITM) begin
            bus.wb_valid <= 1'b1;
            bus.wb_addr <= {tag_q, idx_q, {OFFSET_SIZE{1'b0}}};
            state <= WB;
          end else begin
            bus.snoop_res_valid <= 1'b1;
            bus.set_wr_en <= chg;
            state <= DONE;
          end
        end
        // HITM always leaves M, so the line is always rewritten after the writeback
        WB: if (bus.wb_ready) begin
          bus.wb_valid <= 1'b0;
          bus.snoop_res_valid <= 1'b1;
          bus.set_wr_en <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/llc_snoop_responder.md
# llc_snoop_responder

Snoop-side counterpart of the LLC cache controller. The cache issues bus operations for its own processor requests; this block handles bus operations issued by other caches. For each snooped operation it looks up the addressed set, returns the HIT/HITM/NOHIT snoop result, applies the MESI downgrade or invalidation, and issues a writeback of the modified line before answering HITM. It sits between the bus-snoop interface and the cache's set storage.

## Interface
- ADDR_SIZE, 32, physical address width
- OFFSET_SIZE, 6, line offset bits (64 B line)
- INDEX_SIZE, 14, set index bits (NUM_SETS = 16384)
- TAG_SIZE, 12, tag bits (ADDR_SIZE - INDEX_SIZE - OFFSET_SIZE)
- N_WAY, 16, associativity
- clk  in  1  clock; single clock domain; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- snoop_valid  in  1  snooped operation present
- snoop_ready  out  1  responder can accept an operation
- snoop_op  in  snoop_op_e  READ, WRITE, RWIM or INVALIDATE
- snoop_addr  in  ADDR_SIZE  snooped address
- set_rd_en  out  1  set read strobe
- set_rd_index  out  INDEX_SIZE  set to read
- set_rd_data  in  set_st  set contents; valid one cycle after set_rd_en
- set_wr_en  out  1  set write strobe
- set_wr_index  out  INDEX_SIZE  set to write
- set_wr_data  out  set_st  updated set
- wb_valid  out  1  writeback request
- wb_ready  in  1  writeback accepted
- wb_addr  out  ADDR_SIZE  line-aligned writeback address; offset bits are 0
- snoop_res_valid  out  1  one-cycle pulse carrying the result
- snoop_res  out  snoop_res_e  HIT=2'd0, HITM=2'd1, NOHIT=2'd2
- protocol_err  out  1  one-cycle pulse on an illegal state or a duplicate tag

## Operation
- FSM states: IDLE, LOOKUP, WB, DONE.
- IDLE:
  - snoop_ready = 1.
  - On snoop_valid, accept the operation: register op, tag and index; drive set_rd_en = 1 with set_rd_index = snoop_addr index combinationally in the same cycle; go to LOOKUP.
- LOOKUP:
  - Compare the registered tag against every way with valid = 1.
  - On multiple matches, the lowest way index wins and protocol_err pulses.
  - Compute the result and next MESI state per the rules below.
  - Go to WB if the result is HITM, otherwise go to DONE.
- Transition rules, given the current state of the matching way:
  - READ: M gives HITM and moves to S; E gives HIT and moves to S; S gives HIT and stays S; miss or I gives NOHIT.
  - RWIM: M gives HITM and moves to I; E or S gives HIT and moves to I; miss gives NOHIT.
  - INVALIDATE: S gives HIT and moves to I. M or E is illegal: NOHIT, no change, protocol_err pulses. Miss gives NOHIT.
  - WRITE: always NOHIT, no state change. A match in M or E pulses protocol_err.
- WB:
  - wb_valid stays asserted and wb_addr stays stable until the cycle in which wb_ready = 1; then go to DONE.
- DONE:
  - snoop_res_valid = 1 for exactly one cycle.
  - If the way state changed, set_wr_en = 1 with the full registered set, modified as follows:
    - New mesi value.
    - Dirty = 0 whenever leaving M.
    - Valid = 0 when the new state is I.
    - Tag and plru_bits unchanged; snoops never touch plru_bits.
  - Return to IDLE.

## Timing
- Reset values: snoop_ready = 1; every other output 0, including snoop_res = HIT encoding 0 and all data buses. FSM resets to IDLE.
- Latency, counting the accept cycle as 0:
  - No writeback: snoop_res_valid and set_wr_en in cycle 2.
  - HITM with wb_ready already high: wb_valid in cycle 2, result in cycle 3.
  - Each cycle wb_ready stays low adds one cycle.
- snoop_ready = 0 in LOOKUP, WB and DONE. A new operation is accepted no earlier than the cycle after DONE, so back-to-back throughput is one operation per 3 cycles.
- set_rd_en and set_wr_en are never asserted in the same cycle.
- Reset asserted mid-operation: the next edge returns the FSM to IDLE. No set write or result is produced for the aborted operation, and wb_valid drops.

## Structure
- Package line adds snoop_op_e (READ=0, WRITE=1, INVALIDATE=2, RWIM=3), snoop_res_e, and the encoding constants.
- The block reuses the existing set_st, mesi_e and the size parameters from that package.
- One sub-module: snoop_way_match. It is combinational: set_st plus tag in; hit, way index and multi-hit out.

## Test plan
- READ of a line in M at addr 0x0000_1240 → HITM.
  - wb_addr = 0x0000_1240 in cycle 2, before the result.
  - Way becomes S with dirty = 0.
  - Result in cycle 3 with wb_ready held high.
- RWIM hitting a line in E → HIT in cycle 2; way becomes I with valid = 0.
- INVALIDATE hitting a line in M → NOHIT, protocol_err pulses, set_wr_en never asserted.
- READ to an address whose tag matches no valid way → NOHIT in cycle 2, no write, no wb_valid.
- HITM with wb_ready held low for 5 cycles → wb_valid and wb_addr stable throughout; result in cycle 8.
- rst asserted in the WB cycle → next cycle every output is at its reset value and no set write occurs.
